// File: rtl/kb_event_queue.sv
// PS/2 scan-code decoder with modifier tracking, held-key table and show-ahead event FIFO.
// Events appear one cycle after the completing byte; a push into a full FIFO without a pop is dropped.
module kb_event_queue #(
  parameter int FIFO_DEPTH = 8,
  parameter int NKEYS      = 4
) (
  input  logic                       CLOCK_50,
  input  logic                       clrn,
  input  logic [7:0]                 ps2_data,
  input  logic                       ps2_ready,
  output logic                       ps2_nextdata_n,
  input  logic                       ev_pop,
  output logic                       ev_valid,
  output logic [12:0]                ev_data,
  output logic                       is_shift,
  output logic                       is_ctrl,
  output logic                       is_capital,
  output logic [$clog2(NKEYS+1)-1:0] held_count,
  output logic                       overflow,
  output logic                       is_error
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int KW = (NKEYS > 1) ? $clog2(NKEYS) : 1;
  localparam int CW = $clog2(NKEYS + 1);
  localparam logic [AW:0] PTR_ONE = 1;

  localparam logic [7:0] C_BRK    = 8'hF0;
  localparam logic [7:0] C_EXT    = 8'hE0;
  localparam logic [7:0] C_LSHIFT = 8'h12;
  localparam logic [7:0] C_RSHIFT = 8'h59;
  localparam logic [7:0] C_CTRL   = 8'h14;
  localparam logic [7:0] C_CAPS   = 8'h58;
  localparam logic [7:0] C_BAT    = 8'hAA;
  localparam logic [7:0] C_ACK    = 8'hFA;
  localparam logic [7:0] C_PAUSE  = 8'hE1;

  typedef enum logic [1:0] {ST_IDLE, ST_BRK, ST_EXT, ST_EXT_BRK} state_t;

  state_t            state_q, state_d;
  logic              nextdata_n_q, nextdata_n_d;
  logic              lshift_q, lshift_d;
  logic              rshift_q, rshift_d;
  logic              ctrl_q, ctrl_d;
  logic              caps_q, caps_d;
  logic              caps_held_q, caps_held_d;
  logic [NKEYS-1:0]  held_vld_q, held_vld_d;
  logic [8:0]        held_key_q [NKEYS];
  logic [8:0]        held_key_d [NKEYS];
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic              overflow_q, overflow_d;
  logic              error_q, error_d;
  logic [12:0]       mem_q [FIFO_DEPTH];
  logic [12:0]       mem_d [FIFO_DEPTH];

  logic              consume, complete, cur_ext, cur_brk;
  logic              hit, free;
  logic [KW-1:0]     hit_idx, free_idx;
  logic              push, do_push, do_pop, fifo_full;
  logic [12:0]       ev_word;
  logic [CW-1:0]     cnt;

  always_comb begin
    state_d      = state_q;
    lshift_d     = lshift_q;
    rshift_d     = rshift_q;
    ctrl_d       = ctrl_q;
    caps_d       = caps_q;
    caps_held_d  = caps_held_q;
    held_vld_d   = held_vld_q;
    held_key_d   = held_key_q;
    error_d      = error_q;
    complete     = 1'b0;
    push         = 1'b0;

    // The receiver is not looked at during the strobe cycle, so each byte is taken exactly once.
    consume      = ps2_ready && nextdata_n_q;
    nextdata_n_d = !consume;

    cur_ext = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
    cur_brk = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
    // Event fields sample modifier state before this byte can change it.
    ev_word = {ctrl_q, lshift_q | rshift_q, caps_q, cur_ext, cur_brk, ps2_data};

    hit      = 1'b0;
    hit_idx  = '0;
    free     = 1'b0;
    free_idx = '0;
    for (int i = 0; i < NKEYS; i++) begin
      if (!hit && held_vld_q[i] && (held_key_q[i] == {cur_ext, ps2_data})) begin
        hit     = 1'b1;
        hit_idx = KW'(i);
      end
      if (!free && !held_vld_q[i]) begin
        free     = 1'b1;
        free_idx = KW'(i);
      end
    end

    if (consume) begin
      unique case (state_q)
        ST_IDLE: begin
          if (ps2_data == C_BRK) state_d = ST_BRK;
          else if (ps2_data == C_EXT) state_d = ST_EXT;
          else if (ps2_data != C_BAT && ps2_data != C_ACK && ps2_data != C_PAUSE) complete = 1'b1;
        end
        ST_EXT: begin
          if (ps2_data == C_BRK) state_d = ST_EXT_BRK;
          else if (ps2_data == C_EXT) begin
            error_d = 1'b1;
            state_d = ST_IDLE;
          end else complete = 1'b1;
        end
        ST_BRK, ST_EXT_BRK: begin
          if (ps2_data == C_BRK || ps2_data == C_EXT) begin
            error_d = 1'b1;
            state_d = ST_IDLE;
          end else complete = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (complete) begin
      state_d = ST_IDLE;
      case (ps2_data)
        C_LSHIFT: lshift_d = !cur_brk;
        C_RSHIFT: rshift_d = !cur_brk;
        C_CTRL:   ctrl_d   = !cur_brk;
        C_CAPS: begin
          if (cur_brk) caps_held_d = 1'b0;
          else begin
            if (!caps_held_q) caps_d = !caps_q;
            caps_held_d = 1'b1;
          end
        end
        default: begin
          if (cur_brk) begin
            if (hit) begin
              held_vld_d[hit_idx] = 1'b0;
              push = 1'b1;
            end
          end else if (hit) begin
            push = 1'b1;
          end else if (free) begin
            held_vld_d[free_idx] = 1'b1;
            held_key_d[free_idx] = {cur_ext, ps2_data};
            push = 1'b1;
          end else begin
            error_d = 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    ev_valid   = (wr_ptr_q != rd_ptr_q);
    fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop     = ev_pop && ev_valid;
    do_push    = push && (!fifo_full || do_pop);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    mem_d      = mem_q;
    overflow_d = overflow_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = ev_word;
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (push && !do_push) overflow_d = 1'b1;
    ev_data = ev_valid ? mem_q[rd_ptr_q[AW-1:0]] : 13'd0;
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < NKEYS; i++) cnt = cnt + CW'(held_vld_q[i]);
  end

  always_ff @(posedge CLOCK_50) begin
    if (!clrn) begin
      state_q      <= ST_IDLE;
      nextdata_n_q <= 1'b1;
      lshift_q     <= 1'b0;
      rshift_q     <= 1'b0;
      ctrl_q       <= 1'b0;
      caps_q       <= 1'b0;
      caps_held_q  <= 1'b0;
      held_vld_q   <= '0;
      held_key_q   <= '{default: '0};
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      overflow_q   <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      nextdata_n_q <= nextdata_n_d;
      lshift_q     <= lshift_d;
      rshift_q     <= rshift_d;
      ctrl_q       <= ctrl_d;
      caps_q       <= caps_d;
      caps_held_q  <= caps_held_d;
      held_vld_q   <= held_vld_d;
      held_key_q   <= held_key_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      overflow_q   <= overflow_d;
      error_q      <= error_d;
    end
  end

  // Storage needs no reset: nothing is read until the write pointer moves past it.
  always_ff @(posedge CLOCK_50) begin
    mem_q <= mem_d;
  end

  assign ps2_nextdata_n = nextdata_n_q;
  assign is_shift       = lshift_q | rshift_q;
  assign is_ctrl        = ctrl_q;
  assign is_capital     = caps_q;
  assign held_count     = cnt;
  assign overflow       = overflow_q;
  assign is_error       = error_q;

endmodule
